pc_seq_unit: RTL and testbench

- Parametrised program-counter sequencer for the Beta processor; successor to the single-cycle PC register.
- Generalises PC and offset widths and the trap vectors.
- Adds a fetch-hold (stall) input, edge-latched interrupt request handling with supervisor masking, a defined response to every PCSEL code, and a count of PC advances.
- Sits between the control unit and the instruction memory address port.

---
 rtl/beta_pc_pkg.sv | 20 ++
 rtl/pc_seq_unit_if.sv | 30 +++
 rtl/pc_irq_latch.sv | 41 ++++
 rtl/pc_seq_unit.sv | 82 ++++++++
 tb/tb_pc_seq_unit.sv | 151 +++++++++++++++
 5 files changed

// File: rtl/beta_pc_pkg.sv
// Shared constants for the Beta program-counter sequencer: PCSEL encodings
// and default trap/reset vectors.
package beta_pc_pkg;

  localparam logic [2:0] PCSEL_INC   = 3'd0;
  localparam logic [2:0] PCSEL_BR    = 3'd1;
  localparam logic [2:0] PCSEL_JMP   = 3'd2;
  localparam logic [2:0] PCSEL_ILLOP = 3'd3;
  localparam logic [2:0] PCSEL_XADR  = 3'd4;

  localparam logic [31:0] DEF_RESET_VEC = 32'h8000_0000;
  localparam logic [31:0] DEF_ILLOP_VEC = 32'h8000_0004;
  localparam logic [31:0] DEF_XADR_VEC  = 32'h8000_0008;

  // Codes 5-7 are undefined and behave exactly like ILLOP.
  function automatic logic is_illop_sel(logic [2:0] sel);
    return (sel == PCSEL_ILLOP) || (sel > PCSEL_XADR);
  endfunction

endpackage

// File: rtl/pc_seq_unit_if.sv
// Control-unit-facing bundle of the PC sequencer: PC select inputs, interrupt
// request and the registered/combinational PC outputs.
interface pc_seq_unit_if #(
  parameter int unsigned PC_W  = 32,
  parameter int unsigned OFF_W = 16,
  parameter int unsigned CNT_W = 32
) ();

  logic             stall;
  logic [2:0]       PCSEL;
  logic [OFF_W-1:0] offset;
  logic [PC_W-1:0]  jump_addr;
  logic             irq;
  logic [PC_W-1:0]  PC;
  logic [PC_W-1:0]  PC_PLUS_4;
  logic             irq_taken;
  logic             irq_pending;
  logic [CNT_W-1:0] adv_count;

  modport master (
    output stall, PCSEL, offset, jump_addr, irq,
    input  PC, PC_PLUS_4, irq_taken, irq_pending, adv_count
  );

  modport slave (
    input  stall, PCSEL, offset, jump_addr, irq,
    output PC, PC_PLUS_4, irq_taken, irq_pending, adv_count
  );

endinterface

// File: rtl/pc_irq_latch.sv
// Interrupt front end: rising-edge detect on irq, sticky pending flag, and the
// supervisor/stall/ILLOP mask that decides when the trap is actually taken.
module pc_irq_latch
  import beta_pc_pkg::*;
(
  input  logic       clk,
  input  logic       RESET,
  input  logic       irq,
  input  logic       stall,
  input  logic       pc_msb,
  input  logic [2:0] pcsel,
  output logic       irq_pending,
  output logic       irq_taken
);

  logic irq_d_q;
  logic pend_q;
  logic pend_d;
  logic irq_edge;

  assign irq_edge  = irq & ~irq_d_q;
  // ILLOP has priority, so a colliding pending interrupt must survive it.
  assign irq_taken = pend_q & ~pc_msb & ~stall & ~RESET & ~is_illop_sel(pcsel);

  always_comb begin
    pend_d = irq_edge | (pend_q & ~irq_taken);
  end

  always_ff @(posedge clk) begin
    if (RESET) begin
      irq_d_q <= 1'b0;
      pend_q  <= 1'b0;
    end else begin
      irq_d_q <= irq;
      pend_q  <= pend_d;
    end
  end

  assign irq_pending = pend_q;

endmodule

// File: rtl/pc_seq_unit.sv
// Beta program-counter sequencer: next-PC selection with stall, traps and
// supervisor-bit protection, plus a counter of PC advances.
module pc_seq_unit
  import beta_pc_pkg::*;
#(
  parameter int unsigned     PC_W      = 32,
  parameter int unsigned     OFF_W     = 16,
  parameter int unsigned     CNT_W     = 32,
  parameter logic [PC_W-1:0] RESET_VEC = DEF_RESET_VEC,
  parameter logic [PC_W-1:0] ILLOP_VEC = DEF_ILLOP_VEC,
  parameter logic [PC_W-1:0] XADR_VEC  = DEF_XADR_VEC
) (
  input logic          clk,
  input logic          RESET,
  pc_seq_unit_if.slave bus
);

  localparam int unsigned LoW = PC_W - 1;

  logic [PC_W-1:0]  pc_q, pc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [LoW-1:0]   pc_inc;
  logic [LoW-1:0]   off_words;
  logic [LoW-1:0]   br_low;
  logic [PC_W-1:0]  jmp_tgt;
  logic             irq_taken;
  logic             irq_pending;

  pc_irq_latch u_irq (
    .clk         (clk),
    .RESET       (RESET),
    .irq         (bus.irq),
    .stall       (bus.stall),
    .pc_msb      (pc_q[PC_W-1]),
    .pcsel       (bus.PCSEL),
    .irq_pending (irq_pending),
    .irq_taken   (irq_taken)
  );

  // Low bits only: the supervisor bit never takes a carry.
  assign pc_inc    = pc_q[LoW-1:0] + LoW'(4);
  assign off_words = {{(LoW - OFF_W){bus.offset[OFF_W-1]}}, bus.offset};
  assign br_low    = pc_inc + {off_words[LoW-3:0], 2'b00};
  // A jump may leave supervisor mode but can never enter it.
  assign jmp_tgt   = {pc_q[PC_W-1] & bus.jump_addr[PC_W-1], bus.jump_addr[PC_W-2:2], 2'b00};

  always_comb begin
    pc_d  = pc_q;
    cnt_d = cnt_q;
    if (!bus.stall) begin
      cnt_d = cnt_q + CNT_W'(1);
      if (is_illop_sel(bus.PCSEL)) begin
        pc_d = ILLOP_VEC;
      end else if (irq_taken || (bus.PCSEL == PCSEL_XADR)) begin
        pc_d = XADR_VEC;
      end else begin
        unique case (bus.PCSEL)
          PCSEL_BR:  pc_d = {pc_q[PC_W-1], br_low};
          PCSEL_JMP: pc_d = jmp_tgt;
          default:   pc_d = {pc_q[PC_W-1], pc_inc};
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (RESET) begin
      pc_q  <= RESET_VEC;
      cnt_q <= '0;
    end else begin
      pc_q  <= pc_d;
      cnt_q <= cnt_d;
    end
  end

  assign bus.PC          = pc_q;
  assign bus.PC_PLUS_4   = {pc_q[PC_W-1], pc_inc};
  assign bus.irq_taken   = irq_taken;
  assign bus.irq_pending = irq_pending;
  assign bus.adv_count   = cnt_q;

endmodule

// File: tb/tb_pc_seq_unit.sv
// Self-checking bench for pc_seq_unit: directed walk through the main
// scenarios followed by random traffic against a behavioural PC model.
module tb_pc_seq_unit;

  logic clk = 1'b0;
  logic RESET;
  int   n_assert = 0;
  int   n_fail   = 0;

  pc_seq_unit_if #(.PC_W(32), .OFF_W(16), .CNT_W(32)) bus ();

  pc_seq_unit dut (
    .clk   (clk),
    .RESET (RESET),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Reference state, written from the architectural rules.
  logic [31:0] m_pc;
  logic [31:0] m_cnt;
  logic        m_pend;
  logic        m_irq_prev;
  logic        m_valid = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cycle(input logic rst, input logic st, input logic [2:0] sel,
                       input logic [15:0] off, input logic [31:0] ja, input logic iq);
    logic        illop, taken;
    logic [31:0] nxt;
    logic [30:0] low;
    int          soff;
    RESET         = rst;
    bus.stall     = st;
    bus.PCSEL     = sel;
    bus.offset    = off;
    bus.jump_addr = ja;
    bus.irq       = iq;
    #1;
    illop = (sel == 3'd3) || (sel >= 3'd5);
    taken = m_valid && m_pend && !m_pc[31] && !st && !rst && !illop;
    if (m_valid) begin
      low = m_pc[30:0] + 31'd4;
      chk("pc_plus_4", bus.PC_PLUS_4, {m_pc[31], low});
      chk("irq_taken", {31'd0, bus.irq_taken}, {31'd0, taken});
    end
    if (rst) begin
      m_pc = 32'h8000_0000; m_cnt = 0; m_pend = 1'b0; m_irq_prev = 1'b0; m_valid = 1'b1;
    end else begin
      m_pend     = (iq && !m_irq_prev) || (m_pend && !taken);
      m_irq_prev = iq;
      if (!st) begin
        m_cnt = m_cnt + 1;
        soff  = $signed(off);
        if (illop)                      nxt = 32'h8000_0004;
        else if (taken || sel == 3'd4)  nxt = 32'h8000_0008;
        else if (sel == 3'd1) begin
          low = m_pc[30:0] + 31'd4 + 31'(soff * 4);
          nxt = {m_pc[31], low};
        end else if (sel == 3'd2)       nxt = {m_pc[31] & ja[31], ja[30:2], 2'b00};
        else begin
          low = m_pc[30:0] + 31'd4;
          nxt = {m_pc[31], low};
        end
        m_pc = nxt;
      end
    end
    @(posedge clk);
    #1;
    chk("pc", bus.PC, m_pc);
    chk("adv_count", bus.adv_count, m_cnt);
    chk("irq_pending", {31'd0, bus.irq_pending}, {31'd0, m_pend});
  endtask

  initial begin
    RESET = 1'b1; bus.stall = 1'b0; bus.PCSEL = 3'd0; bus.offset = '0;
    bus.jump_addr = '0; bus.irq = 1'b0;
    @(posedge clk); #1;

    // Reset then increment
    cycle(1, 0, 3'd0, 16'h0, 32'h0, 0);
    cycle(1, 0, 3'd0, 16'h0, 32'h0, 0);
    chk("lit_reset_pc", bus.PC, 32'h8000_0000);
    repeat (3) cycle(0, 0, 3'd0, 16'h0, 32'h0, 0);
    chk("lit_inc_pc", bus.PC, 32'h8000_000C);
    chk("lit_inc_cnt", bus.adv_count, 32'd3);

    // Branch and JMP
    cycle(0, 0, 3'd2, 16'h0, 32'h0000_0100, 0);
    cycle(0, 0, 3'd1, 16'hFFFE, 32'h0, 0);
    chk("lit_branch", bus.PC, 32'h0000_00FC);
    cycle(0, 0, 3'd2, 16'h0, 32'h8000_0213, 0);
    chk("lit_jmp_nomsb", bus.PC, 32'h0000_0210);

    // Stall holds PC and counter
    cycle(0, 0, 3'd2, 16'h0, 32'h0000_0010, 0);
    repeat (4) cycle(0, 1, 3'd1, 16'h0004, 32'h0, 0);
    chk("lit_stall_pc", bus.PC, 32'h0000_0010);
    cycle(0, 0, 3'd1, 16'h0004, 32'h0, 0);
    chk("lit_stall_release", bus.PC, 32'h0000_0024);

    // Interrupt masked in supervisor mode
    cycle(0, 0, 3'd4, 16'h0, 32'h0, 0);
    cycle(0, 0, 3'd2, 16'h0, 32'h8000_0040, 0);
    cycle(0, 1, 3'd0, 16'h0, 32'h0, 1);
    cycle(0, 1, 3'd0, 16'h0, 32'h0, 0);
    chk("lit_sup_pend", {31'd0, bus.irq_pending}, 32'd1);
    chk("lit_sup_pc", bus.PC, 32'h8000_0040);
    cycle(0, 0, 3'd2, 16'h0, 32'h0000_0020, 0);
    cycle(0, 0, 3'd0, 16'h0, 32'h0, 0);
    chk("lit_trap_pc", bus.PC, 32'h8000_0008);
    chk("lit_trap_pend", {31'd0, bus.irq_pending}, 32'd0);

    // ILLOP collides with pending irq; undefined code
    cycle(0, 0, 3'd2, 16'h0, 32'h0000_0020, 0);
    cycle(0, 0, 3'd0, 16'h0, 32'h0, 1);
    cycle(0, 0, 3'd3, 16'h0, 32'h0, 1);
    chk("lit_illop_pc", bus.PC, 32'h8000_0004);
    chk("lit_illop_pend", {31'd0, bus.irq_pending}, 32'd1);
    cycle(0, 0, 3'd4, 16'h0, 32'h0, 0);
    chk("lit_xadr_pc", bus.PC, 32'h8000_0008);
    cycle(0, 0, 3'd6, 16'h0, 32'h0, 0);
    chk("lit_sel6_pc", bus.PC, 32'h8000_0004);

    // Reset discards pending irq; low-bit wrap
    cycle(1, 0, 3'd0, 16'h0, 32'h0, 0);
    chk("lit_rst_pend", {31'd0, bus.irq_pending}, 32'd0);
    cycle(0, 0, 3'd2, 16'h0, 32'h7FFF_FFFC, 0);
    cycle(0, 0, 3'd0, 16'h0, 32'h0, 0);
    chk("lit_wrap", bus.PC, 32'h0000_0000);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      cycle(($urandom_range(39) == 0), ($urandom_range(3) == 0), 3'($urandom_range(7)),
            16'($urandom), $urandom, 1'($urandom_range(1)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
